// File: rtl/tone_decoder_layered.sv
// Layered tone decoder: times tone_in half-periods and locks onto one of 12 table notes.
// Optional TONE_DEGLITCH_EN: require a new input level to hold 4 clks before it counts as an edge.
module tone_decoder_layered #(
  parameter int CLK_HZ      = 50000000,
  parameter int TOL         = 256,
  parameter int MATCH_COUNT = 3,
  parameter int TIMEOUT     = 131071
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tone_in,
  output logic [2:0]  layer_out,
  output logic [3:0]  note_out,
  output logic [18:0] freq_out,
  output logic        valid
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam logic [18:0] TIMEOUT_C = 19'(TIMEOUT);

  // Half-period table in clk cycles; D is 1147 Hz to match the player.
  localparam int TABLE [12] = '{
    CLK_HZ / 880,  CLK_HZ / 932,  CLK_HZ / 986,  CLK_HZ / 1046,
    CLK_HZ / 1108, CLK_HZ / 1147, CLK_HZ / 1244, CLK_HZ / 1318,
    CLK_HZ / 1396, CLK_HZ / 1478, CLK_HZ / 1566, CLK_HZ / 1660
  };

  logic        sync1;
  logic        sync2;
  logic        level;
  logic        tone_edge;
  logic [18:0] counter;
  logic [1:0]  state;
  logic        eval_pending;
  logic [7:0]  match_cnt;
  logic [7:0]  next_cnt;
  logic [3:0]  prev_idx;
  logic [3:0]  hit_idx;
  logic        hit;
  logic        lock_now;

  function automatic logic in_tol(input logic [18:0] meas, input int target);
    int diff;
    diff = int'(meas) - target;
    return (diff <= TOL) && (diff >= -TOL);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
    end
  end

`ifdef TONE_DEGLITCH_EN
  logic [1:0] stable_cnt;

  // The 4th consecutive clk at the new level is the one that declares the edge.
  assign tone_edge = (sync2 != level) && (stable_cnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level      <= 1'b0;
      stable_cnt <= 2'd0;
    end else begin
      if (tone_edge) begin
        level <= sync2;
      end
      if (sync2 == level || tone_edge) begin
        stable_cnt <= 2'd0;
      end else begin
        stable_cnt <= stable_cnt + 2'd1;
      end
    end
  end
`else
  assign tone_edge = (sync2 != level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
    end else begin
      level <= sync2;
    end
  end
`endif

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (!hit && freq_out != '1 && in_tol(freq_out, TABLE[i])) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_comb begin
    next_cnt = 8'd0;
    if (hit) begin
      if (match_cnt != 8'd0 && hit_idx == prev_idx) begin
        next_cnt = (match_cnt == 8'hFF) ? match_cnt : match_cnt + 8'd1;
      end else begin
        next_cnt = 8'd1;
      end
    end
  end

  assign lock_now = (int'(next_cnt) >= MATCH_COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= 19'd0;
    end else if (tone_edge) begin
      counter <= 19'd1;
    end else if (counter != '1) begin
      counter <= counter + 19'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      freq_out     <= 19'd0;
      eval_pending <= 1'b0;
      match_cnt    <= 8'd0;
      prev_idx     <= 4'd0;
      valid        <= 1'b0;
      layer_out    <= 3'd0;
      note_out     <= 4'd0;
    end else begin
      eval_pending <= 1'b0;

      // Interval latched on the previous clk is classified here.
      if (eval_pending) begin
        match_cnt <= next_cnt;
        prev_idx  <= hit_idx;
        if (lock_now) begin
          state     <= LOCKED;
          valid     <= 1'b1;
          layer_out <= 3'b001 << hit_idx[3:2];
          note_out  <= 4'b0001 << hit_idx[1:0];
        end else begin
          state     <= MEASURE;
          valid     <= 1'b0;
          layer_out <= 3'd0;
          note_out  <= 4'd0;
        end
      end

      // An edge coinciding with the timeout wins and is measured.
      if (tone_edge) begin
        if (state == IDLE) begin
          state <= ARM;
        end else begin
          freq_out     <= counter;
          eval_pending <= 1'b1;
        end
      end else if (state != IDLE && counter == TIMEOUT_C) begin
        state     <= IDLE;
        valid     <= 1'b0;
        layer_out <= 3'd0;
        note_out  <= 4'd0;
        match_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder_layered.sv
// Bench for tone_decoder_layered: event-level model plus directed tone scenarios.
// Runs with a scaled clock (CLK_HZ/100, TOL/36, short TIMEOUT) so each scenario stays short.
module tb_tone_decoder_layered;

  localparam int CLK_HZ = 500000;
  localparam int TOL    = 7;
  localparam int MC     = 3;
  localparam int TMO    = 1310;
`ifdef TONE_DEGLITCH_EN
  localparam int LAT = 5;
  localparam logic GLITCH_KEEPS = 1'b1;
`else
  localparam int LAT = 2;
  localparam logic GLITCH_KEEPS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tone_in = 1'b0;
  logic [2:0]  layer_out;
  logic [3:0]  note_out;
  logic [18:0] freq_out;
  logic        valid;

  tone_decoder_layered #(
    .CLK_HZ(CLK_HZ), .TOL(TOL), .MATCH_COUNT(MC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .tone_in(tone_in),
    .layer_out(layer_out), .note_out(note_out), .freq_out(freq_out), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: edges derived from stimulus change times ----------------
  int freqs [12] = '{880, 932, 986, 1046, 1108, 1147, 1244, 1318, 1396, 1478, 1566, 1660};
  int   cyc = 0;
  int   chg_q [$];
  logic m_armed, m_pend, m_valid;
  int   m_last, m_cnt, m_pidx, m_layer, m_note, m_freq;

  task automatic model_eval();
    int idx;
    int d;
    idx = -1;
    for (int i = 0; i < 12; i++) begin
      d = m_freq - CLK_HZ / freqs[i];
      if (d < 0) d = -d;
      if (idx < 0 && d <= TOL) idx = i;
    end
    if (idx < 0) m_cnt = 0;
    else if (m_cnt > 0 && idx == m_pidx) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    else m_cnt = 1;
    if (idx >= 0) m_pidx = idx;
    m_valid = (m_cnt >= MC);
    m_layer = m_valid ? (1 << (idx / 4)) : 0;
    m_note  = m_valid ? (1 << (idx % 4)) : 0;
  endtask

  always @(posedge clk or posedge reset) begin
    logic e;
    if (reset) begin
      chg_q.delete();
      m_armed = 0; m_pend = 0; m_valid = 0;
      m_last = 0; m_cnt = 0; m_pidx = 0; m_layer = 0; m_note = 0; m_freq = 0;
    end else begin
      e = 1'b0;
      cyc++;
      if (chg_q.size() > 0 && chg_q[0] + LAT == cyc) begin
`ifdef TONE_DEGLITCH_EN
        if (chg_q.size() > 1 && chg_q[1] - chg_q[0] < 4) begin
          void'(chg_q.pop_front());
          void'(chg_q.pop_front());
        end else begin
          void'(chg_q.pop_front());
          e = 1'b1;
        end
`else
        void'(chg_q.pop_front());
        e = 1'b1;
`endif
      end
      if (m_pend) begin
        m_pend = 0;
        model_eval();
      end
      if (e) begin
        if (m_armed) begin
          m_freq = cyc - m_last;
          m_pend = 1;
        end
        m_armed = 1;
        m_last  = cyc;
      end else if (m_armed && cyc - m_last == TMO) begin
        m_armed = 0; m_valid = 0; m_cnt = 0; m_layer = 0; m_note = 0;
      end
    end
  end

  logic run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp && !reset)
      check("outputs", 32'({valid, layer_out, note_out, freq_out}),
            32'({m_valid, 3'(m_layer), 4'(m_note), 19'(m_freq)}));
  end

  logic valid_seen = 1'b0;
  always @(negedge clk) if (valid) valid_seen = 1'b1;

  // ---------------- stimulus helpers ----------------
  int since = 0;

  task automatic tog(input int gap);
    while (since < gap) begin
      @(negedge clk);
      since++;
    end
    tone_in = ~tone_in;
    chg_q.push_back(cyc + 1);
    since = 0;
  endtask

  task automatic wait_n(input int k);
    repeat (k) @(negedge clk);
    since += k;
  endtask

  task automatic lock_on(input int hp, input int n_int);
    wait_n(TMO + LAT + 20);
    tog(10);
    for (int i = 0; i < n_int; i++) tog(hp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_layer", 32'(layer_out), 32'd0);
    check("reset_note", 32'(note_out), 32'd0);
    check("reset_freq", 32'(freq_out), 32'd0);
    reset = 1'b0;
    run_cmp = 1'b1;

    // A (880 Hz): lock exactly 2 clk after the 3rd closing edge is detected
    tog(10);
    for (int i = 0; i < 3; i++) tog(568);
    wait_n(LAT + 1);
    check("a_not_yet", 32'(valid), 32'd0);
    wait_n(1);
    check("a_valid", 32'(valid), 32'd1);
    check("a_layer", 32'(layer_out), 32'd1);
    check("a_note", 32'(note_out), 32'd1);
    check("a_freq", 32'(freq_out), 32'd568);
    tog(568);
    wait_n(LAT + 2);
    check("a_hold", 32'(valid), 32'd1);

    // reset mid-measurement clears outputs asynchronously
    wait_n(100);
    reset = 1'b1;
    tone_in = 1'b0;
    #1;
    check("rst_mid_out", 32'({valid, layer_out, note_out, freq_out}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    since = 0;
    wait_n(20);
    check("rst_mid_after", 32'({valid, layer_out, note_out, freq_out}), 32'd0);

    // D (1147 Hz) then switch to G# (1660 Hz)
    tog(10);
    for (int i = 0; i < 4; i++) tog(435);
    wait_n(LAT + 2);
    check("d_layer_note", 32'({valid, layer_out, note_out}), 32'({1'b1, 3'b010, 4'b0010}));
    tog(301);
    wait_n(LAT + 2);
    check("gs_drop", 32'({valid, layer_out, note_out}), 32'd0);
    check("gs_freq", 32'(freq_out), 32'd301);
    tog(301);
    tog(301);
    wait_n(LAT + 2);
    check("gs_relock", 32'({valid, layer_out, note_out}), 32'({1'b1, 3'b100, 4'b1000}));

    // tolerance edges around E (379): +7 and -7 lock, +8 never does
    lock_on(386, 3);
    wait_n(LAT + 2);
    check("e_plus_tol", 32'({valid, layer_out, note_out, freq_out}),
          32'({1'b1, 3'b010, 4'b1000, 19'd386}));
    for (int i = 0; i < 3; i++) tog(372);
    wait_n(LAT + 2);
    check("e_minus_tol", 32'({valid, freq_out}), 32'({1'b1, 19'd372}));
    wait_n(TMO + LAT + 20);
    valid_seen = 1'b0;
    tog(10);
    for (int i = 0; i < 5; i++) tog(387);
    wait_n(LAT + 2);
    check("e_over_tol_seen", 32'(valid_seen), 32'd0);
    check("e_over_tol_freq", 32'(freq_out), 32'd387);

    // interval equal to TIMEOUT is still measured; then silence times out
    lock_on(568, 3);
    tog(TMO);
    wait_n(LAT + 1);
    check("tmo_edge_freq", 32'(freq_out), 32'(TMO));
    wait_n(1);
    check("tmo_edge_valid", 32'(valid), 32'd0);
    tog(568);
    wait_n(LAT + 1);
    check("tmo_edge_remeasure", 32'(freq_out), 32'd568);
    tog(568);
    tog(568);
    wait_n(LAT + 2);
    check("tmo_relock", 32'(valid), 32'd1);
    wait_n(TMO - 2);
    check("tmo_before", 32'(valid), 32'd1);
    wait_n(1);
    check("tmo_after", 32'({valid, layer_out, note_out, freq_out}), 32'({8'd0, 19'd568}));
    tog(10);
    wait_n(LAT + 2);
    check("tmo_idle_arm", 32'({valid, freq_out}), 32'({1'b0, 19'd568}));

    // 2-clk glitch inside a locked half-period
    lock_on(568, 4);
    wait_n(LAT + 2);
    check("gl_locked", 32'(valid), 32'd1);
    tog(200);
    tog(2);
    wait_n(LAT + 3);
    check("gl_valid", 32'(valid), 32'(GLITCH_KEEPS));
    check("gl_freq", 32'(freq_out == 19'd568), 32'(GLITCH_KEEPS));
    tog(366);
    for (int i = 0; i < 3; i++) tog(568);
    wait_n(LAT + 2);
    check("gl_final", 32'({valid, layer_out, note_out}), 32'({1'b1, 3'b001, 4'b0001}));

    wait_n(50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
